data_mem_bus: RTL and testbench

//   Data-side memory subsystem on the CPU's MEM-stage data port (ram_addr_o/ram_data_o/ram_we_o/ram_sel_o/ram_ce_o).

---
 rtl/data_mem_bus_if.sv | 25 ++
 rtl/data_mem_bus.sv | 141 ++++++++++++++
 tb/tb_data_mem_bus.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_bus_if.sv
// Data-port bus between the CPU MEM stage and the data memory subsystem.
//   ce      chip enable (access valid when non-zero)
//   we      1 = write, 0 = read
//   addr    byte address (bits 1:0 ignored by the slave)
//   sel     byte lanes, sel[3] = data[31:24] ... sel[0] = data[7:0]
//   data_i  write data (master -> slave)
//   data_o  read data  (slave -> master, combinational)
interface data_mem_bus_if;
    logic [3:0]  ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (
        output ce, we, addr, sel, data_i,
        input  data_o
    );

    modport slave (
        input  ce, we, addr, sel, data_i,
        output data_o
    );
endinterface

// File: rtl/data_mem_bus.sv
// Data-side memory subsystem: byte-enabled data RAM plus a small MMIO block
// (free-running cycle counter, compare timer with interrupt flag, LED register).
// Read data is combinational; writes commit on the rising clock edge.
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   bus          data-port bus (slave side)
//   led_o        LED register contents
//   timer_irq_o  timer interrupt level (IRQ status masked by EN)
//
// MMIO map (addr[4:2]): 0 CYCLE (RO), 1 CMP, 2 CTRL {IRQ(W1C), EN}, 3 LED[15:0],
// 4..7 read 0 / writes ignored.
module data_mem_bus #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
    input  logic          clk,
    input  logic          rst,
    data_mem_bus_if.slave bus,
    output logic [15:0]   led_o,
    output logic          timer_irq_o
);
    localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [2:0]  OFF_CYC  = 3'd0;
    localparam logic [2:0]  OFF_CMP  = 3'd1;
    localparam logic [2:0]  OFF_CTRL = 3'd2;
    localparam logic [2:0]  OFF_LED  = 3'd3;

    logic [31:0] ram_q [DEPTH];

    logic [31:0] cycle_q, cycle_d;
    logic [31:0] cmp_q,   cmp_d;
    logic        en_q,    en_d;
    logic        irq_q,   irq_d;
    logic [15:0] led_q,   led_d;

    logic                  access;
    logic                  is_mmio;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic [2:0]            reg_off;
    logic                  ram_wr;
    logic                  mmio_wr;
    logic                  rd_en;
    logic                  irq_set;
    logic                  irq_clr;
    logic [31:0]           mmio_rdata;

    // Address bits that play no part in decode (RAM aliases across them).
    logic unused_addr;
    assign unused_addr = ^{bus.addr[27:ADDR_WIDTH+2], bus.addr[1:0]};

    always_comb begin
        access  = (bus.ce != 4'b0000);
        is_mmio = (bus.addr[31:28] == MMIO_BASE[31:28]);
        ram_idx = bus.addr[ADDR_WIDTH+1:2];
        reg_off = bus.addr[4:2];
        // A write presented while reset is asserted is dropped.
        ram_wr  = rst && access && bus.we && !is_mmio;
        mmio_wr = rst && access && bus.we &&  is_mmio;
        rd_en   = rst && access && !bus.we;
    end

    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.sel[i]) begin
                    ram_q[ram_idx][8*i +: 8] <= bus.data_i[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        cycle_d = cycle_q + 32'd1;
        cmp_d   = cmp_q;
        en_d    = en_q;
        led_d   = led_q;
        irq_clr = 1'b0;

        if (mmio_wr) begin
            case (reg_off)
                OFF_CMP: begin
                    for (int i = 0; i < 4; i++) begin
                        if (bus.sel[i]) begin
                            cmp_d[8*i +: 8] = bus.data_i[8*i +: 8];
                        end
                    end
                end
                OFF_CTRL: begin
                    if (bus.sel[0]) begin
                        en_d    = bus.data_i[0];
                        irq_clr = bus.data_i[1];
                    end
                end
                OFF_LED: begin
                    if (bus.sel[0]) led_d[7:0]  = bus.data_i[7:0];
                    if (bus.sel[1]) led_d[15:8] = bus.data_i[15:8];
                end
                default: ;
            endcase
        end

        // Compare uses the pre-increment count; a match beats a same-edge clear.
        irq_set = en_q && (cycle_q == cmp_q);
        irq_d   = irq_set || (irq_q && !irq_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_q <= 32'd0;
            cmp_q   <= 32'hFFFF_FFFF;
            en_q    <= 1'b0;
            irq_q   <= 1'b0;
            led_q   <= 16'd0;
        end else begin
            cycle_q <= cycle_d;
            cmp_q   <= cmp_d;
            en_q    <= en_d;
            irq_q   <= irq_d;
            led_q   <= led_d;
        end
    end

    always_comb begin
        case (reg_off)
            OFF_CYC:  mmio_rdata = cycle_q;
            OFF_CMP:  mmio_rdata = cmp_q;
            OFF_CTRL: mmio_rdata = {30'd0, irq_q, en_q};
            OFF_LED:  mmio_rdata = {16'd0, led_q};
            default:  mmio_rdata = 32'd0;
        endcase

        if (rd_en) begin
            bus.data_o = is_mmio ? mmio_rdata : ram_q[ram_idx];
        end else begin
            bus.data_o = 32'd0;
        end
    end

    assign led_o       = led_q;
    assign timer_irq_o = irq_q && en_q;
endmodule

// File: tb/tb_data_mem_bus.sv
module tb_data_mem_bus;
    localparam logic [31:0] A_CYC  = 32'h1000_0000;
    localparam logic [31:0] A_CMP  = 32'h1000_0004;
    localparam logic [31:0] A_CTRL = 32'h1000_0008;
    localparam logic [31:0] A_LED  = 32'h1000_000C;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] led_o;
    logic        timer_irq_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_bus_if bus();

    data_mem_bus #(
        .ADDR_WIDTH (10),
        .MMIO_BASE  (32'h1000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .led_o       (led_o),
        .timer_irq_o (timer_irq_o)
    );

    task automatic bus_idle();
        bus.ce     = 4'b0000;
        bus.we     = 1'b0;
        bus.addr   = 32'd0;
        bus.sel    = 4'b0000;
        bus.data_i = 32'd0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(posedge clk);
        #1;
        bus.ce     = 4'b1111;
        bus.we     = 1'b1;
        bus.addr   = a;
        bus.sel    = s;
        bus.data_i = d;
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d);
        @(posedge clk);
        #1;
        bus.ce   = 4'b1111;
        bus.we   = 1'b0;
        bus.addr = a;
        bus.sel  = 4'b1111;
        #1;
        d = bus.data_o;
        bus_idle();
    endtask

    task automatic apply_reset();
        bus_idle();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        bus_idle();
        rst = 1'b0;
        #1;
        checks++;
        if (led_o !== 16'h0000) begin
            errors++;
            $display("FAIL reset_led: got %h expected %h", led_o, 16'h0000);
        end
        checks++;
        if (timer_irq_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b expected %b", timer_irq_o, 1'b0);
        end
        bus.ce = 4'b1111; bus.addr = A_CMP; bus.sel = 4'b1111;
        #1;
        checks++;
        if (bus.data_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_data_o: got %h expected %h", bus.data_o, 32'd0);
        end
        bus_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        do_read(A_CYC, d);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL reset_cycle_first: got %h expected %h", d, 32'd1);
        end
        do_read(A_CYC, d);
        checks++;
        if (d !== 32'd2) begin
            errors++;
            $display("FAIL reset_cycle_second: got %h expected %h", d, 32'd2);
        end
        do_read(A_CMP, d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL reset_cmp: got %h expected %h", d, 32'hFFFF_FFFF);
        end
        do_read(A_CTRL, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %h expected %h", d, 32'd0);
        end
    endtask

    task automatic test_ram();
        logic [31:0] d;
        do_write(32'h40, 32'hDEAD_BEEF, 4'b1111);
        do_read(32'h40, d);
        checks++;
        if (d !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL ram_full_write: got %h expected %h", d, 32'hDEAD_BEEF);
        end
        do_write(32'h40, 32'h0000_0011, 4'b0001);
        do_read(32'h40, d);
        checks++;
        if (d !== 32'hDEAD_BE11) begin
            errors++;
            $display("FAIL ram_lane0_write: got %h expected %h", d, 32'hDEAD_BE11);
        end
        do_write(32'h40, 32'hFFFF_FFFF, 4'b0000);
        do_read(32'h40, d);
        checks++;
        if (d !== 32'hDEAD_BE11) begin
            errors++;
            $display("FAIL ram_sel_zero: got %h expected %h", d, 32'hDEAD_BE11);
        end
        do_write(32'h44, 32'h1234_5678, 4'b1111);
        do_write(32'h47, 32'hCAFE_0000, 4'b1100);
        do_read(32'h44, d);
        checks++;
        if (d !== 32'hCAFE_5678) begin
            errors++;
            $display("FAIL ram_upper_lanes: got %h expected %h", d, 32'hCAFE_5678);
        end
        do_read(32'h40, d);
        checks++;
        if (d !== 32'hDEAD_BE11) begin
            errors++;
            $display("FAIL ram_neighbour: got %h expected %h", d, 32'hDEAD_BE11);
        end
    endtask

    task automatic test_mmio();
        logic [31:0] d;
        logic [31:0] v;
        do_write(A_LED, 32'h1234_ABCD, 4'b1111);
        checks++;
        if (led_o !== 16'hABCD) begin
            errors++;
            $display("FAIL led_output: got %h expected %h", led_o, 16'hABCD);
        end
        do_read(A_LED, d);
        checks++;
        if (d !== 32'h0000_ABCD) begin
            errors++;
            $display("FAIL led_read: got %h expected %h", d, 32'h0000_ABCD);
        end
        do_write(A_LED, 32'h0000_00EE, 4'b0001);
        checks++;
        if (led_o !== 16'hABEE) begin
            errors++;
            $display("FAIL led_lane0: got %h expected %h", led_o, 16'hABEE);
        end
        do_write(A_CMP, 32'h0000_1200, 4'b0010);
        do_read(A_CMP, d);
        checks++;
        if (d !== 32'hFFFF_12FF) begin
            errors++;
            $display("FAIL cmp_lane1: got %h expected %h", d, 32'hFFFF_12FF);
        end
        do_read(A_CYC, v);
        do_write(A_CYC, 32'd0, 4'b1111);
        do_read(A_CYC, d);
        checks++;
        if (d !== v + 32'd3) begin
            errors++;
            $display("FAIL cycle_write_ignored: got %h expected %h", d, v + 32'd3);
        end
        do_read(32'h1000_0010, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reserved_read: got %h expected %h", d, 32'd0);
        end
        do_write(32'h1000_0040, 32'h5555_5555, 4'b1111);
        do_read(32'h40, d);
        checks++;
        if (d !== 32'hDEAD_BE11) begin
            errors++;
            $display("FAIL mmio_not_ram: got %h expected %h", d, 32'hDEAD_BE11);
        end
    endtask

    task automatic test_alias_ce();
        logic [31:0] d;
        do_read(32'h2000_0040, d);
        checks++;
        if (d !== 32'hDEAD_BE11) begin
            errors++;
            $display("FAIL alias_high: got %h expected %h", d, 32'hDEAD_BE11);
        end
        do_read(32'h0000_1040, d);
        checks++;
        if (d !== 32'hDEAD_BE11) begin
            errors++;
            $display("FAIL alias_bit12: got %h expected %h", d, 32'hDEAD_BE11);
        end
        @(posedge clk);
        #1;
        bus.ce = 4'b0000; bus.we = 1'b0; bus.addr = 32'h40; bus.sel = 4'b1111;
        #1;
        checks++;
        if (bus.data_o !== 32'd0) begin
            errors++;
            $display("FAIL ce_zero_read: got %h expected %h", bus.data_o, 32'd0);
        end
        bus.we = 1'b1; bus.data_i = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        bus.ce = 4'b1111; bus.sel = 4'b0000;
        #1;
        checks++;
        if (bus.data_o !== 32'd0) begin
            errors++;
            $display("FAIL write_data_o_zero: got %h expected %h", bus.data_o, 32'd0);
        end
        bus_idle();
        do_read(32'h40, d);
        checks++;
        if (d !== 32'hDEAD_BE11) begin
            errors++;
            $display("FAIL ce_zero_no_write: got %h expected %h", d, 32'hDEAD_BE11);
        end
    endtask

    task automatic test_timer();
        logic [31:0] d;
        logic [31:0] n;
        logic [31:0] cmpv;
        bit found;
        apply_reset();
        do_write(A_CMP, 32'd20, 4'b1111);
        do_write(A_CTRL, 32'd1, 4'b1111);
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            do_read(A_CYC, d);
            if (d == 32'd20) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL timer_reach_20: got %h expected %h", d, 32'd20);
        end
        checks++;
        if (timer_irq_o !== 1'b0) begin
            errors++;
            $display("FAIL timer_irq_before: got %b expected %b", timer_irq_o, 1'b0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (timer_irq_o !== 1'b1) begin
            errors++;
            $display("FAIL timer_irq_rise: got %b expected %b", timer_irq_o, 1'b1);
        end
        do_read(A_CTRL, d);
        checks++;
        if (d !== 32'd3) begin
            errors++;
            $display("FAIL timer_ctrl_status: got %h expected %h", d, 32'd3);
        end
        do_write(A_CTRL, 32'd3, 4'b1111);
        checks++;
        if (timer_irq_o !== 1'b0) begin
            errors++;
            $display("FAIL timer_w1c: got %b expected %b", timer_irq_o, 1'b0);
        end
        do_read(A_CTRL, d);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL timer_en_kept: got %h expected %h", d, 32'd1);
        end
        do_read(A_CYC, n);
        cmpv = n + 32'd10;
        do_write(A_CMP, cmpv, 4'b1111);
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            do_read(A_CYC, d);
            if (d == cmpv - 32'd1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL timer_reach_cmp: got %h expected %h", d, cmpv - 32'd1);
        end
        do_write(A_CTRL, 32'd3, 4'b1111);
        checks++;
        if (timer_irq_o !== 1'b1) begin
            errors++;
            $display("FAIL timer_set_wins: got %b expected %b", timer_irq_o, 1'b1);
        end
        do_write(A_CTRL, 32'd0, 4'b1111);
        checks++;
        if (timer_irq_o !== 1'b0) begin
            errors++;
            $display("FAIL timer_mask: got %b expected %b", timer_irq_o, 1'b0);
        end
        do_read(A_CTRL, d);
        checks++;
        if (d !== 32'd2) begin
            errors++;
            $display("FAIL timer_irq_held: got %h expected %h", d, 32'd2);
        end
        do_write(A_CTRL, 32'd1, 4'b1111);
        checks++;
        if (timer_irq_o !== 1'b1) begin
            errors++;
            $display("FAIL timer_unmask: got %b expected %b", timer_irq_o, 1'b1);
        end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] d;
        bit found;
        do_write(A_LED, 32'h0000_00FF, 4'b1111);
        found = 1'b0;
        for (int k = 0; k < 700 && !found; k++) begin
            do_read(A_CYC, d);
            if (d >= 32'd500) found = 1'b1;
        end
        checks++;
        if (!found || timer_irq_o !== 1'b1 || led_o !== 16'h00FF) begin
            errors++;
            $display("FAIL midrun_setup: got cycle %h irq %b led %h expected cycle>=500 irq 1 led 00ff",
                     d, timer_irq_o, led_o);
        end
        @(posedge clk);
        #3;
        bus.ce = 4'b1111; bus.we = 1'b0; bus.addr = A_LED; bus.sel = 4'b1111;
        rst = 1'b0;
        #1;
        checks++;
        if (led_o !== 16'h0000 || timer_irq_o !== 1'b0 || bus.data_o !== 32'd0) begin
            errors++;
            $display("FAIL midrun_async_clear: got led %h irq %b data_o %h expected 0000 0 00000000",
                     led_o, timer_irq_o, bus.data_o);
        end
        bus.we = 1'b1; bus.addr = 32'h40; bus.data_i = 32'h0000_0000;
        @(posedge clk);
        #1;
        bus_idle();
        @(negedge clk);
        rst = 1'b1;
        do_read(A_CYC, d);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL midrun_cycle_restart: got %h expected %h", d, 32'd1);
        end
        do_read(A_CTRL, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL midrun_ctrl: got %h expected %h", d, 32'd0);
        end
        do_read(A_CMP, d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL midrun_cmp: got %h expected %h", d, 32'hFFFF_FFFF);
        end
        do_read(32'h40, d);
        checks++;
        if (d !== 32'hDEAD_BE11) begin
            errors++;
            $display("FAIL midrun_ram_kept: got %h expected %h", d, 32'hDEAD_BE11);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ram();
        test_mmio();
        test_alias_ce();
        test_timer();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
